pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have inputs D_icode_i[3:0], E_icode_i[3:0], M_icode_i[3:0], W_icode_i[3:0]: stage instruction codes.
REQ-005 SHALL have inputs d_srcA_i[3:0], d_srcB_i[3:0], E_dstM_i[3:0]: decode sources and E-stage memory destination.
REQ-006 SHALL have inputs e_Cnd_i[0:0], m_stat_i[2:0], W_stat_i[2:0], hold_req_i[0:0]: branch outcome, stage status, freeze request.
REQ-007 SHALL have 1-bit outputs F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o, set_cc_o, halted_o.
REQ-008 SHALL have outputs state_o[1:0] and stat_o[2:0].
REQ-009 SHALL have outputs cycle_cnt_o, stall_cnt_o, bubble_cnt_o, retire_cnt_o, each [CNT_W-1:0].

Function
REQ-010 SHALL use encodings: IHALT=0, INOP=1, IRET=9, IJXX=7, IOPQ=6, IMRMOVQ=5, IPOPQ=B, RNONE=F, SAOK=1, SHLT=2, SADR=3, SINS=4.
REQ-011 SHALL compute load_use = E_icode_i in {IMRMOVQ,IPOPQ} AND E_dstM_i!=RNONE AND E_dstM_i in {d_srcA_i,d_srcB_i}.
REQ-012 SHALL compute ret_hz = IRET in {D_icode_i,E_icode_i,M_icode_i}; mispred = E_icode_i==IJXX AND e_Cnd_i==0.
REQ-013 SHALL compute exc_m = m_stat_i in {SHLT,SADR,SINS}; exc_w = W_stat_i in {SHLT,SADR,SINS}.
REQ-014 SHALL implement FSM RUN(0), FREEZE(1), HALT(2), registered, exposed on state_o.
REQ-015 RUN: exc_w -> HALT (highest priority); else hold_req_i -> FREEZE; else stay.
REQ-016 FREEZE: exc_w -> HALT; else hold_req_i==0 -> RUN; else stay.
REQ-017 HALT: SHALL remain until reset; no input exits it.
REQ-018 In RUN, outputs SHALL be combinational from current inputs: F_stall=load_use|ret_hz; D_stall=load_use; D_bubble=mispred|(ret_hz&~load_use); E_bubble=mispred|load_use; M_bubble=exc_m|exc_w; W_stall=exc_w.
REQ-019 In FREEZE: F_stall=D_stall=E_bubble=1, D_bubble=0, M_bubble/W_stall per REQ-018 (downstream drains).
REQ-020 In HALT: F_stall=D_stall=E_bubble=M_bubble=W_stall=1, D_bubble=0.
REQ-021 set_cc_o SHALL be 1 only when state==RUN, E_icode_i==IOPQ, ~exc_m, ~exc_w.
REQ-022 Simultaneous load_use and mispred SHALL give E_bubble=1, D_bubble=1, D_stall=1 (D_bubble dominates downstream).
REQ-023 stat_o SHALL load W_stat_i on the RUN/FREEZE->HALT edge and hold; SAOK otherwise.
REQ-024 halted_o SHALL equal (state==HALT), registered.
REQ-025 Counters: cycle increments every cycle; stall when F_stall_o=1; bubble when D_bubble_o|E_bubble_o|M_bubble_o; retire when W_stat_i==SAOK, W_icode_i!=INOP, W_stall_o==0.
REQ-026 Counters SHALL saturate at all-ones, never wrap; counting continues in HALT except retire.

Reset
REQ-027 rst_i=1 at a rising edge SHALL set state=RUN, stat_o=SAOK, halted_o=0, all counters 0, regardless of current state including mid-FREEZE/HALT.
REQ-028 During reset cycles, combinational outputs SHALL follow RUN-state equations; counters SHALL not increment.

Configuration
REQ-029 With PIPE_CTRL_PERF_EN defined, counters SHALL be implemented per REQ-025/026.
REQ-030 Without PIPE_CTRL_PERF_EN, counter registers SHALL be absent and the four count outputs tied to 0; all other behaviour unchanged.

Verification
REQ-031 Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
REQ-032 Mispredict: E_icode=7, e_Cnd=0, no load_use -> D_bubble=1, E_bubble=1, F_stall=0.
REQ-033 Ret: M_icode=9 for 1 cycle, others NOP -> F_stall=1, D_bubble=1 that cycle; load_use with D_icode=9 -> D_bubble=0.
REQ-034 Halt: W_stat=2 -> W_stall=1, M_bubble=1 same cycle; next cycle state_o=2, halted_o=1, stat_o=2; W_stat back to 1 -> state stays 2.
REQ-035 Freeze: hold_req 1 for 3 cycles -> state_o=1 for 3 cycles, F_stall=D_stall=E_bubble=1, then RUN; hold_req with W_stat=3 same cycle -> HALT, stat_o=3.
REQ-036 Counters (PERF_EN, CNT_W=4): 20 cycles after reset -> cycle_cnt=15 saturated; rst_i mid-run -> all counters 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Bundle of pipeline-status inputs and hazard-control /
//                performance outputs exchanged with pipe_ctrl.
//                master = pipeline datapath side, slave = controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    // Stage instruction codes
    logic [3:0]       D_icode_i;
    logic [3:0]       E_icode_i;
    logic [3:0]       M_icode_i;
    logic [3:0]       W_icode_i;
    // Register dependencies
    logic [3:0]       d_srcA_i;
    logic [3:0]       d_srcB_i;
    logic [3:0]       E_dstM_i;
    // Branch outcome, stage status, freeze request
    logic [0:0]       e_Cnd_i;
    logic [2:0]       m_stat_i;
    logic [2:0]       W_stat_i;
    logic [0:0]       hold_req_i;
    // Pipeline control
    logic             F_stall_o;
    logic             D_stall_o;
    logic             D_bubble_o;
    logic             E_bubble_o;
    logic             M_bubble_o;
    logic             W_stall_o;
    logic             set_cc_o;
    logic             halted_o;
    logic [1:0]       state_o;
    logic [2:0]       stat_o;
    // Performance counters
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] bubble_cnt_o;
    logic [CNT_W-1:0] retire_cnt_o;

    modport master (
        output D_icode_i, E_icode_i, M_icode_i, W_icode_i,
        output d_srcA_i, d_srcB_i, E_dstM_i,
        output e_Cnd_i, m_stat_i, W_stat_i, hold_req_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o,
        input  W_stall_o, set_cc_o, halted_o, state_o, stat_o,
        input  cycle_cnt_o, stall_cnt_o, bubble_cnt_o, retire_cnt_o
    );

    modport slave (
        input  D_icode_i, E_icode_i, M_icode_i, W_icode_i,
        input  d_srcA_i, d_srcB_i, E_dstM_i,
        input  e_Cnd_i, m_stat_i, W_stat_i, hold_req_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o,
        output W_stall_o, set_cc_o, halted_o, state_o, stat_o,
        output cycle_cnt_o, stall_cnt_o, bubble_cnt_o, retire_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Hazard / exception control for a 5-stage Y86-style pipeline.
//                Detects load-use, return and mispredict hazards, drives the
//                stage stall/bubble controls, and runs a RUN/FREEZE/HALT
//                state machine. Optional saturating performance counters are
//                enabled with the PIPE_CTRL_PERF_EN macro; without it the
//                count outputs are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    pipe_ctrl_if.slave  bus
);

    localparam logic [3:0] c_INOP    = 4'h1;
    localparam logic [3:0] c_IRET    = 4'h9;
    localparam logic [3:0] c_IJXX    = 4'h7;
    localparam logic [3:0] c_IOPQ    = 4'h6;
    localparam logic [3:0] c_IMRMOVQ = 4'h5;
    localparam logic [3:0] c_IPOPQ   = 4'hB;
    localparam logic [3:0] c_RNONE   = 4'hF;
    localparam logic [2:0] c_SAOK    = 3'd1;
    localparam logic [2:0] c_SHLT    = 3'd2;
    localparam logic [2:0] c_SADR    = 3'd3;
    localparam logic [2:0] c_SINS    = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_mode;
    logic [2:0] r_stat;
    logic       r_halted;

    logic w_load_use, w_ret_hz, w_mispred, w_exc_m, w_exc_w;
    logic w_f_stall, w_d_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall;
    logic w_set_cc;

    // Hazard and exception detection from current stage contents
    always_comb begin
        w_load_use = ((bus.E_icode_i == c_IMRMOVQ) || (bus.E_icode_i == c_IPOPQ)) &&
                     (bus.E_dstM_i != c_RNONE) &&
                     ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
        w_ret_hz   = (bus.D_icode_i == c_IRET) || (bus.E_icode_i == c_IRET) ||
                     (bus.M_icode_i == c_IRET);
        w_mispred  = (bus.E_icode_i == c_IJXX) && (bus.e_Cnd_i == 1'b0);
        w_exc_m    = (bus.m_stat_i == c_SHLT) || (bus.m_stat_i == c_SADR) ||
                     (bus.m_stat_i == c_SINS);
        w_exc_w    = (bus.W_stat_i == c_SHLT) || (bus.W_stat_i == c_SADR) ||
                     (bus.W_stat_i == c_SINS);
    end

    // While reset is held the controls behave as in RUN
    assign w_mode = rst_i ? ST_RUN : r_state;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_RUN;
        else       r_state <= w_next;
    end

    // Next-state selection and per-state pipeline controls
    always_comb begin
        w_next     = r_state;
        w_f_stall  = w_load_use | w_ret_hz;
        w_d_stall  = w_load_use;
        w_d_bubble = w_mispred | (w_ret_hz & ~w_load_use);
        w_e_bubble = w_mispred | w_load_use;
        w_m_bubble = w_exc_m | w_exc_w;
        w_w_stall  = w_exc_w;
        w_set_cc   = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (w_exc_w)              w_next = ST_HALT;
                else if (bus.hold_req_i[0]) w_next = ST_FREEZE;
            end
            ST_FREEZE: begin
                if (w_exc_w)              w_next = ST_HALT;
                else if (!bus.hold_req_i[0]) w_next = ST_RUN;
            end
            default: w_next = ST_HALT;
        endcase

        unique case (w_mode)
            ST_RUN: begin
                w_set_cc = (bus.E_icode_i == c_IOPQ) & ~w_exc_m & ~w_exc_w;
            end
            ST_FREEZE: begin
                // Front end frozen; memory/writeback keep draining
                w_f_stall  = 1'b1;
                w_d_stall  = 1'b1;
                w_d_bubble = 1'b0;
                w_e_bubble = 1'b1;
            end
            default: begin
                w_f_stall  = 1'b1;
                w_d_stall  = 1'b1;
                w_d_bubble = 1'b0;
                w_e_bubble = 1'b1;
                w_m_bubble = 1'b1;
                w_w_stall  = 1'b1;
            end
        endcase
    end

    // Capture the faulting status on entry to HALT; halted flag tracks state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat   <= c_SAOK;
            r_halted <= 1'b0;
        end else begin
            if ((r_state != ST_HALT) && (w_next == ST_HALT)) r_stat <= bus.W_stat_i;
            r_halted <= (w_next == ST_HALT);
        end
    end

    assign bus.F_stall_o  = w_f_stall;
    assign bus.D_stall_o  = w_d_stall;
    assign bus.D_bubble_o = w_d_bubble;
    assign bus.E_bubble_o = w_e_bubble;
    assign bus.M_bubble_o = w_m_bubble;
    assign bus.W_stall_o  = w_w_stall;
    assign bus.set_cc_o   = w_set_cc;
    assign bus.halted_o   = r_halted;
    assign bus.state_o    = r_state;
    assign bus.stat_o     = r_stat;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cycle_cnt, r_stall_cnt, r_bubble_cnt, r_retire_cnt;
    logic             w_retire;

    // A retire needs a real, healthy instruction leaving writeback
    assign w_retire = (bus.W_stat_i == c_SAOK) && (bus.W_icode_i != c_INOP) &&
                      !w_w_stall && (r_state != ST_HALT);

    // Saturating event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (r_cycle_cnt != '1)
                r_cycle_cnt <= r_cycle_cnt + c_ONE;
            if (w_f_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + c_ONE;
            if ((w_d_bubble | w_e_bubble | w_m_bubble) && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + c_ONE;
            if (w_retire && (r_retire_cnt != '1))
                r_retire_cnt <= r_retire_cnt + c_ONE;
        end
    end

    assign bus.cycle_cnt_o  = r_cycle_cnt;
    assign bus.stall_cnt_o  = r_stall_cnt;
    assign bus.bubble_cnt_o = r_bubble_cnt;
    assign bus.retire_cnt_o = r_retire_cnt;
`else
    // Writeback icode only feeds the retire counter
    logic w_unused_perf;
    assign w_unused_perf = ^bus.W_icode_i;

    assign bus.cycle_cnt_o  = '0;
    assign bus.stall_cnt_o  = '0;
    assign bus.bubble_cnt_o = '0;
    assign bus.retire_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl: directed hazard, freeze,
//                halt and counter scenarios followed by randomized traffic
//                compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus();
    pipe_ctrl #(.CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Reference model: 0=RUN 1=FREEZE 2=HALT
    int m_state = 0, m_stat = 1;
    int m_cyc = 0, m_stl = 0, m_bub = 0, m_ret = 0;
    bit e_fs, e_ds, e_db, e_eb, e_mb, e_ws, e_cc;
    bit hold_s = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_exc(input int s);
        return (s == 2) || (s == 3) || (s == 4);
    endfunction

    task automatic eval_model();
        int  mode;
        bit  lu, rh, mp, em, ew;
        mode = rst ? 0 : m_state;
        lu = ((bus.E_icode_i == 5) || (bus.E_icode_i == 11)) && (bus.E_dstM_i != 15) &&
             ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
        rh = (bus.D_icode_i == 9) || (bus.E_icode_i == 9) || (bus.M_icode_i == 9);
        mp = (bus.E_icode_i == 7) && (bus.e_Cnd_i == 0);
        em = is_exc(int'(bus.m_stat_i));
        ew = is_exc(int'(bus.W_stat_i));
        e_mb = em | ew;
        e_ws = ew;
        e_cc = 1'b0;
        if (mode == 0) begin
            e_fs = lu | rh;  e_ds = lu;  e_db = mp | (rh & !lu);  e_eb = mp | lu;
            e_cc = (bus.E_icode_i == 6) && !em && !ew;
        end else begin
            e_fs = 1; e_ds = 1; e_db = 0; e_eb = 1;
            if (mode == 2) begin e_mb = 1; e_ws = 1; end
        end
    endtask

    // Sample combinational controls mid-cycle
    task automatic settle();
        #2;
        eval_model();
        chk("F_stall",  32'(bus.F_stall_o),  32'(e_fs));
        chk("D_stall",  32'(bus.D_stall_o),  32'(e_ds));
        chk("D_bubble", 32'(bus.D_bubble_o), 32'(e_db));
        chk("E_bubble", 32'(bus.E_bubble_o), 32'(e_eb));
        chk("M_bubble", 32'(bus.M_bubble_o), 32'(e_mb));
        chk("W_stall",  32'(bus.W_stall_o),  32'(e_ws));
        chk("set_cc",   32'(bus.set_cc_o),   32'(e_cc));
    endtask

    // Advance one edge, update the model, check registered outputs
    task automatic tick();
        bit ew, ret;
        ew  = is_exc(int'(bus.W_stat_i));
        ret = (bus.W_stat_i == 1) && (bus.W_icode_i != 1) && !e_ws && (m_state != 2);
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_stat = 1; m_cyc = 0; m_stl = 0; m_bub = 0; m_ret = 0;
        end else begin
            if (m_cyc < CMAX) m_cyc++;
            if (e_fs && m_stl < CMAX) m_stl++;
            if ((e_db || e_eb || e_mb) && m_bub < CMAX) m_bub++;
            if (ret && m_ret < CMAX) m_ret++;
            if (m_state != 2 && ew) begin
                m_state = 2; m_stat = int'(bus.W_stat_i);
            end else if (m_state == 0 && bus.hold_req_i == 1) m_state = 1;
            else if (m_state == 1 && bus.hold_req_i == 0) m_state = 0;
        end
        #1;
        chk("state",      32'(bus.state_o),      32'(m_state));
        chk("halted",     32'(bus.halted_o),     32'(m_state == 2));
        chk("stat",       32'(bus.stat_o),       32'(m_stat));
        chk("cycle_cnt",  32'(bus.cycle_cnt_o),  PERF ? 32'(m_cyc) : 32'd0);
        chk("stall_cnt",  32'(bus.stall_cnt_o),  PERF ? 32'(m_stl) : 32'd0);
        chk("bubble_cnt", 32'(bus.bubble_cnt_o), PERF ? 32'(m_bub) : 32'd0);
        chk("retire_cnt", 32'(bus.retire_cnt_o), PERF ? 32'(m_ret) : 32'd0);
    endtask

    task automatic set_nop();
        bus.D_icode_i = 4'h1; bus.E_icode_i = 4'h1; bus.M_icode_i = 4'h1; bus.W_icode_i = 4'h1;
        bus.d_srcA_i = 4'hF; bus.d_srcB_i = 4'hF; bus.E_dstM_i = 4'hF;
        bus.e_Cnd_i = 1'b1; bus.m_stat_i = 3'd1; bus.W_stat_i = 3'd1; bus.hold_req_i = 1'b0;
    endtask

    function automatic logic [3:0] rnd_icode();
        case ($urandom_range(0, 8))
            0: return 4'h0;  1: return 4'h1;  2: return 4'h9;
            3: return 4'h7;  4: return 4'h6;  5: return 4'h5;
            6: return 4'hB;  7: return 4'h2;  default: return 4'h3;
        endcase
    endfunction

    function automatic logic [3:0] rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    function automatic logic [2:0] rnd_stat(input int exc_odds);
        if ($urandom_range(0, exc_odds) == 0) return 3'($urandom_range(2, 4));
        if ($urandom_range(0, 15) == 0) return 3'd0;
        return 3'd1;
    endfunction

    initial begin
        set_nop();
        rst = 1'b1;
        settle(); tick();
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_stat",  32'(bus.stat_o),  32'd1);
        rst = 1'b0;

        // Load-use
        set_nop(); bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h3; bus.d_srcA_i = 4'h3;
        settle();
        chk("lu_fstall", 32'(bus.F_stall_o), 32'd1);
        chk("lu_dstall", 32'(bus.D_stall_o), 32'd1);
        chk("lu_ebub",   32'(bus.E_bubble_o), 32'd1);
        chk("lu_dbub",   32'(bus.D_bubble_o), 32'd0);
        tick();

        // Mispredict
        set_nop(); bus.E_icode_i = 4'h7; bus.e_Cnd_i = 1'b0;
        settle();
        chk("mp_dbub",   32'(bus.D_bubble_o), 32'd1);
        chk("mp_ebub",   32'(bus.E_bubble_o), 32'd1);
        chk("mp_fstall", 32'(bus.F_stall_o),  32'd0);
        tick();

        // Return in M, then return in D masked by load-use
        set_nop(); bus.M_icode_i = 4'h9;
        settle();
        chk("ret_fstall", 32'(bus.F_stall_o),  32'd1);
        chk("ret_dbub",   32'(bus.D_bubble_o), 32'd1);
        tick();
        set_nop(); bus.D_icode_i = 4'h9; bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h3; bus.d_srcB_i = 4'h3;
        settle();
        chk("retlu_dbub", 32'(bus.D_bubble_o), 32'd0);
        tick();

        // Condition-code update
        set_nop(); bus.E_icode_i = 4'h6;
        settle();
        chk("setcc", 32'(bus.set_cc_o), 32'd1);
        tick();

        // Freeze for three cycles
        set_nop(); bus.hold_req_i = 1'b1;
        settle(); tick();
        chk("frz_state0", 32'(bus.state_o), 32'd1);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("frz_fstall", 32'(bus.F_stall_o),  32'd1);
            chk("frz_dstall", 32'(bus.D_stall_o),  32'd1);
            chk("frz_ebub",   32'(bus.E_bubble_o), 32'd1);
            tick();
            chk("frz_state", 32'(bus.state_o), 32'd1);
        end
        bus.hold_req_i = 1'b0;
        settle(); tick();
        chk("frz_exit", 32'(bus.state_o), 32'd0);

        // Halt on writeback exception
        set_nop(); bus.W_stat_i = 3'd2;
        settle();
        chk("hlt_wstall", 32'(bus.W_stall_o),  32'd1);
        chk("hlt_mbub",   32'(bus.M_bubble_o), 32'd1);
        tick();
        chk("hlt_state",  32'(bus.state_o),  32'd2);
        chk("hlt_halted", 32'(bus.halted_o), 32'd1);
        chk("hlt_stat",   32'(bus.stat_o),   32'd2);
        bus.W_stat_i = 3'd1;
        settle(); tick();
        chk("hlt_sticky", 32'(bus.state_o), 32'd2);

        // Reset out of HALT, then freeze request racing an exception
        rst = 1'b1; set_nop();
        settle(); tick();
        chk("hrst_state", 32'(bus.state_o), 32'd0);
        rst = 1'b0;
        bus.hold_req_i = 1'b1; bus.W_stat_i = 3'd3;
        settle(); tick();
        chk("frzexc_state", 32'(bus.state_o), 32'd2);
        chk("frzexc_stat",  32'(bus.stat_o),  32'd3);

        // Counter saturation and mid-run reset
        rst = 1'b1; set_nop();
        settle(); tick();
        rst = 1'b0;
        bus.W_icode_i = 4'h6;
        for (int i = 0; i < 20; i++) begin settle(); tick(); end
        chk("cyc_sat", 32'(bus.cycle_cnt_o), PERF ? 32'd15 : 32'd0);
        rst = 1'b1;
        settle(); tick();
        chk("cyc_rst", 32'(bus.cycle_cnt_o), 32'd0);
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) hold_s = ~hold_s;
            bus.D_icode_i = rnd_icode(); bus.E_icode_i = rnd_icode();
            bus.M_icode_i = rnd_icode(); bus.W_icode_i = rnd_icode();
            bus.d_srcA_i = rnd_reg(); bus.d_srcB_i = rnd_reg(); bus.E_dstM_i = rnd_reg();
            bus.e_Cnd_i = 1'($urandom_range(0, 1));
            bus.m_stat_i = rnd_stat(6);
            bus.W_stat_i = rnd_stat(40);
            bus.hold_req_i = hold_s;
            rst = ($urandom_range(0, 59) == 0) || (m_state == 2 && $urandom_range(0, 7) == 0);
            settle(); tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
